arb_mux: RTL and testbench

- Parametrised, registered N-channel successor to the 2:1 datapath mux.
- Selects one of CHANNELS valid/ready source channels, using fixed-priority, round-robin or forced-select arbitration.
- Drives a single output register with valid/ready handshake.
- Sits between multiple requesters (PC/IR address path, debug port, DMA) and the shared MU0 memory/bus port.

---
 rtl/arb_mux_pkg.sv | 18 +
 rtl/arb_mux_if.sv | 28 ++
 rtl/arb_mux_rr_arbiter.sv | 29 ++
 rtl/arb_mux.sv | 97 +++++++++
 tb/tb_arb_mux.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/arb_mux_pkg.sv
// Shared arbitration mode encodings and width helper for the arb_mux slice.
package arb_mux_pkg;

    localparam logic [1:0] MODE_FIXED = 2'b00;
    localparam logic [1:0] MODE_RR    = 2'b01;
    localparam logic [1:0] MODE_FORCE = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    // Index width for n channels; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        if (w == 0) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Channel-side and output-side valid/ready bundle between requesters and arb_mux.
interface arb_mux_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    import arb_mux_pkg::*;

    localparam int SEL_W = clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] inData;
    logic [CHANNELS-1:0]       inValid;
    logic [CHANNELS-1:0]       inReady;
    logic [WIDTH-1:0]          outData;
    logic                      outValid;
    logic                      outReady;
    logic [SEL_W-1:0]          outChannel;

    modport master (
        output inData, inValid, outReady,
        input  inReady, outData, outValid, outChannel
    );

    modport slave (
        input  inData, inValid, outReady,
        output inReady, outData, outValid, outChannel
    );

endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// Rotating-priority one-hot arbiter; a zero pointer gives plain fixed priority.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [CHANNELS-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = (int'(ptr) + i) % CHANNELS;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// Registered N-channel arbitrating mux: mode select, output register, rotation
// pointer and the valid/ready handshake toward the shared memory port.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int  WIDTH    = 16,
    parameter int  CHANNELS = 4,
    localparam int SEL_W    = clog2(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] forceSel,
    arb_mux_if.slave         bus
);

    logic [SEL_W-1:0]    rr_ptr;
    logic [SEL_W-1:0]    arb_ptr;
    logic                use_force;
    logic [CHANNELS-1:0] arb_grant;
    logic [CHANNELS-1:0] force_mask;
    logic [CHANNELS-1:0] grant;
    logic [CHANNELS-1:0] ready;
    logic                can_load;
    logic                xfer;
    logic [WIDTH-1:0]    sel_data;
    logic [SEL_W-1:0]    sel_idx;

    logic [WIDTH-1:0]    out_data_q;
    logic [SEL_W-1:0]    out_chan_q;
    logic                out_valid_q;

    // Reserved mode falls through to fixed priority.
    always_comb begin
        arb_ptr   = '0;
        use_force = 1'b0;
        case (mode)
            MODE_RR:               arb_ptr   = rr_ptr;
            MODE_FORCE:            use_force = 1'b1;
            MODE_FIXED, MODE_RSVD: arb_ptr   = '0;
        endcase
    end

    rr_arbiter #(.CHANNELS(CHANNELS)) u_rr_arbiter (
        .req   (bus.inValid),
        .ptr   (arb_ptr),
        .grant (arb_grant)
    );

    // An out-of-range forceSel matches no bit and so grants nothing.
    always_comb begin
        force_mask = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            force_mask[i] = (forceSel == SEL_W'(i));
        end
    end

    assign grant    = use_force ? (bus.inValid & force_mask) : arb_grant;
    assign can_load = !out_valid_q | bus.outReady;
    assign ready    = grant & {CHANNELS{can_load}};
    assign xfer     = |(bus.inValid & ready);

    always_comb begin
        sel_data = '0;
        sel_idx  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_data = bus.inData[i*WIDTH +: WIDTH];
                sel_idx  = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr      <= '0;
        end else begin
            if (xfer) begin
                out_data_q  <= sel_data;
                out_chan_q  <= sel_idx;
                out_valid_q <= 1'b1;
                rr_ptr      <= (sel_idx == SEL_W'(CHANNELS-1)) ? '0 : sel_idx + 1'b1;
            end else if (bus.outReady) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.inReady    = ready;
    assign bus.outData    = out_data_q;
    assign bus.outValid   = out_valid_q;
    assign bus.outChannel = out_chan_q;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: directed scenarios then randomized traffic,
// checked against a channel-index reference model of the arbitration rules.
module tb_arb_mux;

    localparam int WIDTH = 16;
    localparam int CH    = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [1:0] force_sel = 2'b00;

    arb_mux_if #(.WIDTH(WIDTH), .CHANNELS(CH)) bus();

    arb_mux #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .forceSel (force_sel),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  chan;
    } item_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    item_t       sb[$];
    logic [15:0] cur_data[CH];
    logic [15:0] dir_data[CH];
    bit          pending[CH];
    bit          rand_data = 1'b0;
    int          m_ptr  = 0;
    bit          m_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference: which channel wins, or -1 when nobody may be granted.
    function automatic int pick(input logic [3:0] v, input logic [1:0] m,
                                input logic [1:0] fs, input int ptr);
        int start;
        int c;
        if (m == 2'b10) return v[fs] ? int'(fs) : -1;
        start = (m == 2'b01) ? ptr : 0;
        for (int i = 0; i < CH; i++) begin
            c = (start + i) % CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic step(input logic [1:0] m, input logic [1:0] fs,
                        input logic [3:0] req, input logic ordy);
        logic [3:0] v;
        logic [3:0] exp_ready;
        int         k;
        bit         can_load;
        item_t      it;
        @(posedge clk);
        #1;
        mode          = m;
        force_sel     = fs;
        bus.outReady  = ordy;
        for (int c = 0; c < CH; c++) begin
            if (!pending[c] && req[c]) begin
                pending[c]  = 1'b1;
                cur_data[c] = rand_data ? 16'($urandom) : dir_data[c];
            end
            v[c] = pending[c];
            bus.inData[c*WIDTH +: WIDTH] = cur_data[c];
        end
        bus.inValid = v;
        #1;
        k         = pick(v, m, fs, m_ptr);
        can_load  = !m_full || ordy;
        exp_ready = (k >= 0 && can_load) ? 4'(1 << k) : 4'b0000;
        chk("in_ready", 32'(bus.inReady), 32'(exp_ready));
        chk("out_valid", 32'(bus.outValid), 32'(m_full));
        if (exp_ready != 4'b0000) begin
            it.data = cur_data[k];
            it.chan = 2'(k);
            sb.push_back(it);
            pending[k] = 1'b0;
            m_ptr      = (k + 1) % CH;
            m_full     = 1'b1;
        end else if (ordy) begin
            m_full = 1'b0;
        end
    endtask

    logic [15:0] last_data;
    bit          hold_prev = 1'b0;

    always @(negedge clk) begin
        item_t it;
        if (rst_n) begin
            if (hold_prev) chk("hold_data", 32'(bus.outData), 32'(last_data));
            if (bus.outValid && bus.outReady) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL scoreboard_empty actual=word ch%0d required=no word", bus.outChannel);
                end else begin
                    it = sb.pop_front();
                    chk("out_data", 32'(bus.outData), 32'(it.data));
                    chk("out_channel", 32'(bus.outChannel), 32'(it.chan));
                end
            end
            hold_prev = bus.outValid && !bus.outReady;
            last_data = bus.outData;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.inValid  = '0;
        bus.inData   = '0;
        bus.outReady = 1'b0;
        for (int c = 0; c < CH; c++) begin
            cur_data[c] = '0;
            pending[c]  = 1'b0;
            dir_data[c] = 16'h0010 + 16'(c);
        end

        #12;
        chk("rst_out_valid", 32'(bus.outValid), 32'd0);
        chk("rst_out_data", 32'(bus.outData), 32'd0);
        chk("rst_out_channel", 32'(bus.outChannel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed priority: ch1 wins every cycle, ch3 starves until ch1 stops.
        dir_data[1] = 16'h0001;
        dir_data[3] = 16'h0003;
        repeat (6) step(2'b00, 2'd0, 4'b1010, 1'b1);
        repeat (3) step(2'b00, 2'd0, 4'b0000, 1'b1);

        // Round-robin wrap.
        for (int c = 0; c < CH; c++) dir_data[c] = 16'h0010 + 16'(c);
        repeat (5) step(2'b01, 2'd0, 4'b1111, 1'b1);

        // Back-pressure then release.
        repeat (5) step(2'b01, 2'd0, 4'b1111, 1'b0);
        repeat (3) step(2'b01, 2'd0, 4'b1111, 1'b1);

        // Forced select, then forced channel goes idle and output drains.
        repeat (4) step(2'b10, 2'd2, 4'b1111, 1'b1);
        repeat (3) step(2'b10, 2'd2, 4'b1011, 1'b1);

        // Reserved mode, then round-robin switched to fixed mid-stream.
        repeat (4) step(2'b11, 2'd0, 4'b1111, 1'b1);
        repeat (2) step(2'b01, 2'd0, 4'b1111, 1'b1);
        repeat (3) step(2'b00, 2'd0, 4'b1111, 1'b1);
        repeat (2) step(2'b01, 2'd0, 4'b1111, 1'b1);

        // Reset while a word is held under back-pressure.
        step(2'b01, 2'd0, 4'b0100, 1'b1);
        step(2'b01, 2'd0, 4'b0000, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.outValid), 32'd0);
        chk("midrst_out_data", 32'(bus.outData), 32'd0);
        chk("midrst_out_channel", 32'(bus.outChannel), 32'd0);
        sb.delete();
        m_full = 1'b0;
        m_ptr  = 0;
        for (int c = 0; c < CH; c++) pending[c] = 1'b0;
        bus.inValid = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) step(2'b01, 2'd0, 4'b1111, 1'b1);

        // Randomized traffic.
        rand_data = 1'b1;
        repeat (400) begin
            step(2'($urandom), 2'($urandom), 4'($urandom),
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        rand_data = 1'b0;
        repeat (20) step(2'b00, 2'd0, 4'b0000, 1'b1);
        @(negedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
